// File: rtl/segment_sequencer.sv
// Stepper segment sequencer: pops motion records from the record fifo and
// turns each into evenly spaced step pulses with per-segment direction levels.
module segment_sequencer #(
   parameter int WordSize    = 8,
   parameter int RecordWords = 16,
   parameter int NumAxes     = 8,
   parameter int PulseWidth  = 4,
   parameter int CountBits   = 32
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              enable,
   input  logic                              abort,
   input  logic                              fifo_empty,
   input  logic [WordSize*RecordWords-1:0]   fifo_record,
   output logic                              fifo_read_en,
   output logic [NumAxes-1:0]                step,
   output logic [NumAxes-1:0]                dir,
   output logic                              busy,
   output logic                              underrun,
   input  logic                              clear_underrun,
   output logic [15:0]                       segments_done
);

   // state | meaning
   // IDLE  | waiting for enable and a complete record
   // FETCH | pop record, latch dir/mask/count, load period counter
   // RUN   | period counter running, step low
   // PULSE | step high for PulseWidth cycles, period counter still running
   typedef enum logic [1:0] {IDLE, FETCH, RUN, PULSE} state_t;

   localparam int                   PwBits     = $clog2(PulseWidth + 1);
   localparam logic [PwBits-1:0]    PwLoad     = PwBits'(PulseWidth);
   localparam logic [PwBits-1:0]    PwOne      = PwBits'(1);
   localparam logic [CountBits-1:0] CntOne     = CountBits'(1);
   localparam logic [CountBits-1:0] CntZero    = '0;
   localparam logic [CountBits-1:0] MinPeriod  = CountBits'(PulseWidth + 1);

   state_t                 state, state_next;
   logic [NumAxes-1:0]     mask;
   logic [CountBits-1:0]   steps_left;
   logic [CountBits-1:0]   period;
   logic [CountBits-1:0]   cnt;
   logic [PwBits-1:0]      pw_cnt;
   logic                   abort_seen;

   logic [CountBits-1:0]   rec_count;
   logic [CountBits-1:0]   rec_period;
   logic [CountBits-1:0]   peff;
   logic [NumAxes-1:0]     rec_dir;
   logic [NumAxes-1:0]     rec_mask;
   logic                   pulse_end;
   logic                   seg_end;
   logic                   unused_record;

   assign rec_count     = fifo_record[CountBits-1:0];
   assign rec_period    = fifo_record[CountBits +: CountBits];
   assign rec_dir       = fifo_record[2*CountBits +: NumAxes];
   assign rec_mask      = fifo_record[2*CountBits + 8 +: NumAxes];
   assign unused_record = ^fifo_record;

   // The pulse lives inside the period, so the period must exceed the pulse.
   assign peff      = (rec_period < MinPeriod) ? MinPeriod : rec_period;
   assign pulse_end = (state == PULSE) && (pw_cnt == PwOne);

   always_comb begin
      seg_end = 1'b0;
      case (state)
         FETCH:   seg_end = (rec_count == CntZero);
         RUN:     seg_end = abort;
         PULSE:   seg_end = pulse_end && ((steps_left == CntOne) || abort_seen || abort);
         default: seg_end = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (enable && !fifo_empty) state_next = FETCH;
         FETCH: state_next = (rec_count == CntZero) ? IDLE : RUN;
         RUN: begin
            if (abort)              state_next = IDLE;
            else if (cnt == CntOne) state_next = PULSE;
         end
         PULSE: if (pulse_end) state_next = seg_end ? IDLE : RUN;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      fifo_read_en = (state == FETCH);
      busy         = (state != IDLE);
      step         = (state == PULSE) ? mask : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask       <= '0;
         dir        <= '0;
         steps_left <= '0;
         period     <= '0;
         cnt        <= '0;
         pw_cnt     <= '0;
         abort_seen <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               mask       <= rec_mask;
               dir        <= rec_dir;
               steps_left <= rec_count;
               period     <= peff;
               cnt        <= peff;
               abort_seen <= 1'b0;
            end
            RUN: begin
               if (cnt == CntOne) begin
                  cnt    <= period;
                  pw_cnt <= PwLoad;
               end else begin
                  cnt <= cnt - CntOne;
               end
            end
            PULSE: begin
               cnt <= cnt - CntOne;
               if (pulse_end) begin
                  steps_left <= steps_left - CntOne;
                  abort_seen <= 1'b0;
               end else begin
                  pw_cnt <= pw_cnt - PwOne;
                  if (abort) abort_seen <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // A new underrun event takes priority over a coincident clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         segments_done <= '0;
         underrun      <= 1'b0;
      end else begin
         if (seg_end) segments_done <= segments_done + 16'd1;
         if (seg_end && enable && fifo_empty) underrun <= 1'b1;
         else if (clear_underrun)             underrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_segment_sequencer.sv
// Scoreboard bench for segment_sequencer: directed records push expected
// output events (with cycle gaps) that a monitor pops and compares.
module tb_segment_sequencer;

   localparam int NumAxes = 8;

   localparam int EV_READ  = 0;
   localparam int EV_DIR   = 1;
   localparam int EV_RISE  = 2;
   localparam int EV_FALL  = 3;
   localparam int EV_DONE  = 4;
   localparam int EV_UNDER = 5;

   typedef struct {
      int kind;
      int val;
      int gap;
   } ev_t;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                enable;
   logic                abort;
   logic                fifo_empty;
   logic [127:0]        fifo_record;
   logic                fifo_read_en;
   logic [NumAxes-1:0]  step;
   logic [NumAxes-1:0]  dir;
   logic                busy;
   logic                underrun;
   logic                clear_underrun;
   logic [15:0]         segments_done;

   logic [127:0]        mem [0:31];
   logic [4:0]          wr_ptr = '0;
   logic [4:0]          rd_ptr = '0;

   int                  checks = 0;
   int                  fails  = 0;
   int                  cyc    = 0;
   int                  last_ev_cyc = 0;
   int                  n_reads = 0;
   int                  n_rises = 0;
   int                  n_falls = 0;
   ev_t                 exp_q[$];

   segment_sequencer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .abort          (abort),
      .fifo_empty     (fifo_empty),
      .fifo_record    (fifo_record),
      .fifo_read_en   (fifo_read_en),
      .step           (step),
      .dir            (dir),
      .busy           (busy),
      .underrun       (underrun),
      .clear_underrun (clear_underrun),
      .segments_done  (segments_done)
   );

   always #5 clk = ~clk;

   assign fifo_empty  = (rd_ptr == wr_ptr);
   assign fifo_record = mem[rd_ptr];

   always @(posedge clk) begin
      if (fifo_read_en) rd_ptr <= rd_ptr + 5'd1;
   end

   function automatic logic [127:0] mk_rec(input logic [31:0] n, input logic [31:0] p,
                                           input logic [7:0] d, input logic [7:0] m);
      mk_rec = {48'h0, m, d, p, n};
   endfunction

   function automatic string kname(input int k);
      case (k)
         EV_READ:  kname = "read";
         EV_DIR:   kname = "dir";
         EV_RISE:  kname = "rise";
         EV_FALL:  kname = "fall";
         EV_DONE:  kname = "done";
         default:  kname = "underrun";
      endcase
   endfunction

   task automatic push(input logic [127:0] rec);
      mem[wr_ptr] = rec;
      wr_ptr = wr_ptr + 5'd1;
   endtask

   task automatic expect_ev(input int kind, input int val, input int gap);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      e.gap  = gap;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: observed event compared with the head of the expected queue.
   task automatic emit(input int kind, input int val);
      ev_t e;
      int  gap;
      gap = cyc - last_ev_cyc;
      last_ev_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL unexpected_event: got %s val 'h%0h at cycle %0d, expected none",
                  kname(kind), val, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.val != val || (e.gap >= 0 && e.gap != gap)) begin
            fails++;
            $display("FAIL event_%s: got %s val 'h%0h gap %0d, expected %s val 'h%0h gap %0d",
                     kname(e.kind), kname(kind), val, gap, kname(e.kind), e.val, e.gap);
         end
      end
   endtask

   initial begin : monitor
      logic [NumAxes-1:0] p_step;
      logic [NumAxes-1:0] p_dir;
      logic [15:0]        p_done;
      logic               p_under;
      p_step = '0; p_dir = '0; p_done = '0; p_under = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_n === 1'b1) begin
            if (fifo_read_en) begin n_reads++; emit(EV_READ, 0); end
            if (dir != p_dir) emit(EV_DIR, int'(dir));
            if (step != '0 && p_step == '0) begin n_rises++; emit(EV_RISE, int'(step)); end
            if (step == '0 && p_step != '0) begin n_falls++; emit(EV_FALL, 0); end
            if (segments_done != p_done) emit(EV_DONE, int'(segments_done));
            if (underrun != p_under) emit(EV_UNDER, int'(underrun));
         end
         p_step = step; p_dir = dir; p_done = segments_done; p_under = underrun;
      end
   end

   task automatic wait_drain(input int max_cyc, input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s_timeout: got %0d events outstanding, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic wait_count(input int target, input bit rises, input int max_cyc, input string name);
      int n;
      n = 0;
      while (((rises ? n_rises : n_falls) < target) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk(name, rises ? n_rises : n_falls, target);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      enable = 1'b0;
      abort = 1'b0;
      clear_underrun = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got no end of test, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int r0;
      rst_n = 1'b0; enable = 1'b0; abort = 1'b0; clear_underrun = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_step", int'(step), 0);
      chk("reset_busy", int'(busy), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_dir", int'(dir), 0);
      chk("reset_read_en", int'(fifo_read_en), 0);
      chk("reset_underrun", int'(underrun), 0);
      chk("reset_done", int'(segments_done), 0);

      // Single segment N=3 P=10
      push(mk_rec(3, 10, 8'h01, 8'h01));
      expect_ev(EV_READ, 0, -1);
      expect_ev(EV_DIR, 1, 1);
      expect_ev(EV_RISE, 1, 10); expect_ev(EV_FALL, 0, 4);
      expect_ev(EV_RISE, 1, 6);  expect_ev(EV_FALL, 0, 4);
      expect_ev(EV_RISE, 1, 6);  expect_ev(EV_FALL, 0, 4);
      expect_ev(EV_DONE, 1, 0);  expect_ev(EV_UNDER, 1, 0);
      enable = 1'b1;
      wait_drain(200, "single");
      repeat (2) @(negedge clk);
      chk("single_busy", int'(busy), 0);
      chk("single_done", int'(segments_done), 1);
      expect_ev(EV_UNDER, 0, -1);
      clear_underrun = 1'b1;
      @(negedge clk);
      clear_underrun = 1'b0;
      wait_drain(10, "clear");
      chk("clear_underrun", int'(underrun), 0);

      // Clamp (P=1 -> 5) then zero-count record
      do_reset();
      push(mk_rec(2, 1, 8'h02, 8'h03));
      push(mk_rec(0, 0, 8'h05, 8'h01));
      expect_ev(EV_READ, 0, -1);
      expect_ev(EV_DIR, 2, 1);
      expect_ev(EV_RISE, 3, 5); expect_ev(EV_FALL, 0, 4);
      expect_ev(EV_RISE, 3, 1); expect_ev(EV_FALL, 0, 4);
      expect_ev(EV_DONE, 1, 0);
      expect_ev(EV_READ, 0, 1);
      expect_ev(EV_DIR, 5, 1);
      expect_ev(EV_DONE, 2, 0);
      enable = 1'b1;
      wait_drain(200, "clamp");
      repeat (20) @(negedge clk);
      chk("clamp_busy", int'(busy), 0);
      chk("clamp_done", int'(segments_done), 2);
      chk("clamp_underrun", int'(underrun), 0);

      // Back-to-back records
      do_reset();
      push(mk_rec(2, 8, 8'h00, 8'h01));
      push(mk_rec(1, 6, 8'hFF, 8'h01));
      expect_ev(EV_READ, 0, -1);
      expect_ev(EV_RISE, 1, 9); expect_ev(EV_FALL, 0, 4);
      expect_ev(EV_RISE, 1, 4); expect_ev(EV_FALL, 0, 4);
      expect_ev(EV_DONE, 1, 0);
      expect_ev(EV_READ, 0, 1);
      expect_ev(EV_DIR, 255, 1);
      expect_ev(EV_RISE, 1, 6); expect_ev(EV_FALL, 0, 4);
      expect_ev(EV_DONE, 2, 0); expect_ev(EV_UNDER, 1, 0);
      enable = 1'b1;
      r0 = n_reads;
      wait_drain(200, "b2b");
      repeat (20) @(negedge clk);
      chk("b2b_reads", n_reads - r0, 2);
      chk("b2b_done", int'(segments_done), 2);

      // Abort during third pulse
      do_reset();
      r0 = n_rises;
      push(mk_rec(100, 20, 8'h01, 8'h01));
      expect_ev(EV_READ, 0, -1);
      expect_ev(EV_DIR, 1, 1);
      expect_ev(EV_RISE, 1, 20); expect_ev(EV_FALL, 0, 4);
      expect_ev(EV_RISE, 1, 16); expect_ev(EV_FALL, 0, 4);
      expect_ev(EV_RISE, 1, 16); expect_ev(EV_FALL, 0, 4);
      expect_ev(EV_DONE, 1, 0);  expect_ev(EV_UNDER, 1, 0);
      enable = 1'b1;
      wait_count(r0 + 3, 1'b1, 200, "abort_pulse_rise3");
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_drain(50, "abort_pulse");
      repeat (60) @(negedge clk);
      chk("abort_pulse_pulses", n_rises - r0, 3);
      chk("abort_pulse_done", int'(segments_done), 1);

      // Abort in RUN, with coincident underrun clear
      do_reset();
      r0 = n_falls;
      push(mk_rec(100, 20, 8'h01, 8'h01));
      expect_ev(EV_READ, 0, -1);
      expect_ev(EV_DIR, 1, 1);
      expect_ev(EV_RISE, 1, 20); expect_ev(EV_FALL, 0, 4);
      expect_ev(EV_DONE, 1, -1); expect_ev(EV_UNDER, 1, 0);
      enable = 1'b1;
      wait_count(r0 + 1, 1'b0, 200, "abort_run_fall1");
      repeat (5) @(negedge clk);
      abort = 1'b1;
      clear_underrun = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      clear_underrun = 1'b0;
      wait_drain(10, "abort_run");
      repeat (60) @(negedge clk);
      chk("abort_run_busy", int'(busy), 0);
      chk("abort_run_underrun", int'(underrun), 1);

      // Enable gating, then async reset mid-pulse
      do_reset();
      push(mk_rec(5, 10, 8'h01, 8'h01));
      r0 = n_reads;
      repeat (50) @(negedge clk);
      chk("gate_no_read", n_reads - r0, 0);
      expect_ev(EV_READ, 0, -1);
      expect_ev(EV_DIR, 1, 1);
      expect_ev(EV_RISE, 1, 10);
      enable = 1'b1;
      wait_drain(100, "gate_run");
      @(negedge clk);
      chk("mid_pulse_step_before", int'(step), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_step", int'(step), 0);
      chk("async_dir", int'(dir), 0);
      chk("async_busy", int'(busy), 0);
      enable = 1'b0;
      push(mk_rec(1, 10, 8'h01, 8'h01));
      @(negedge clk);
      rst_n = 1'b1;
      r0 = n_reads;
      repeat (50) @(negedge clk);
      chk("post_reset_no_read", n_reads - r0, 0);
      expect_ev(EV_READ, 0, -1);
      expect_ev(EV_DIR, 1, 1);
      enable = 1'b1;
      wait_drain(20, "post_reset_fetch");
      do_reset();

      chk("final_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
